rk4_tx_framer: RTL and testbench



---
 rtl/rk4_tx_framer_if.sv | 25 ++
 rtl/rk4_tx_framer.sv | 171 +++++++++++++++++
 tb/tb_rk4_tx_framer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rk4_tx_framer_if.sv
// Handshake bundle between the RK4 solver, the record framer and uart_tx.
// Transfers: rec_valid&&rec_ready pushes a record, tx_valid is a one-cycle byte strobe, eos_ready pulses on the marker's last byte.
interface rk4_tx_framer_if;
    logic        rec_valid;
    logic [31:0] rec_ti;
    logic [31:0] rec_yi;
    logic        rec_ready;
    logic        eos_valid;
    logic        eos_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    // Environment side: drives records, end-of-stream requests and uart_tx readiness.
    modport master (
        output rec_valid, rec_ti, rec_yi, eos_valid, tx_ready,
        input  rec_ready, eos_ready, tx_valid, tx_data
    );

    // Framer side.
    modport slave (
        input  rec_valid, rec_ti, rec_yi, eos_valid, tx_ready,
        output rec_ready, eos_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/rk4_tx_framer.sv
// Buffers (ti, yi) records in a FIFO and serialises them little-endian onto uart_tx, then an end-of-stream marker.
// Optional macro RK4_FRAMER_CSUM_EN appends an XOR checksum byte to every record.
module rk4_tx_framer #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MARKER     = 32'hDEADBEEF
) (
    input  logic                          clk,
    input  logic                          rst,
    rk4_tx_framer_if.slave                bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [2:0]                    o_dbg_state
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef RK4_FRAMER_CSUM_EN
    localparam int          SHIFT_W   = 72;
    localparam logic [3:0]  REC_BYTES = 4'd9;
`else
    localparam int          SHIFT_W   = 64;
    localparam logic [3:0]  REC_BYTES = 4'd8;
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_SEND      = 3'd2,
        S_GAP       = 3'd3,
        S_MARK_LOAD = 3'd4,
        S_MARK_SEND = 3'd5,
        S_MARK_GAP  = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [63:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_next;
    logic                r_rec_ready;
    logic [SHIFT_W-1:0]  r_shift;
    logic [3:0]          r_byte_cnt;
    logic                w_push;
    logic                w_pop;
    logic                w_issue;
    logic [63:0]         w_head;
    logic [SHIFT_W-1:0]  w_load_word;

    // rec_ready is registered from the post-update count, so a pop never opens a slot in the same cycle.
    assign bus.rec_ready = r_rec_ready && !rst;
    assign w_push        = bus.rec_valid && bus.rec_ready;
    assign w_pop         = (r_state == S_LOAD);
    assign w_head        = r_mem[r_rd_ptr];
    assign fifo_count    = r_count;
    assign o_dbg_state   = r_state;

`ifdef RK4_FRAMER_CSUM_EN
    logic [7:0] w_csum;
    always_comb begin
        w_csum = 8'h00;
        for (int i = 0; i < 8; i++) begin
            w_csum = w_csum ^ w_head[8*i +: 8];
        end
    end
    assign w_load_word = {w_csum, w_head};
`else
    assign w_load_word = w_head;
`endif

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.rec_yi, bus.rec_ti};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rec_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count     <= w_count_next;
            r_rec_ready <= (w_count_next != CNT_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Records win over end-of-stream in IDLE, so the marker never lands inside or ahead of buffered data.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_state_next = S_LOAD;
                end else if (bus.eos_valid) begin
                    w_state_next = S_MARK_LOAD;
                end
            end
            S_LOAD: w_state_next = S_SEND;
            S_SEND: begin
                if (bus.tx_ready) begin
                    w_issue      = 1'b1;
                    w_state_next = S_GAP;
                end
            end
            S_GAP: w_state_next = (r_byte_cnt != 4'd0) ? S_SEND : S_IDLE;
            S_MARK_LOAD: w_state_next = S_MARK_SEND;
            S_MARK_SEND: begin
                if (bus.tx_ready) begin
                    w_issue      = 1'b1;
                    w_state_next = (r_byte_cnt == 4'd1) ? S_IDLE : S_MARK_GAP;
                end
            end
            S_MARK_GAP: w_state_next = (r_byte_cnt != 4'd0) ? S_MARK_SEND : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= '0;
            r_byte_cnt <= 4'd0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_shift    <= w_load_word;
                    r_byte_cnt <= REC_BYTES;
                end
                S_MARK_LOAD: begin
                    r_shift    <= {{(SHIFT_W-32){1'b0}}, MARKER};
                    r_byte_cnt <= 4'd4;
                end
                S_SEND, S_MARK_SEND: begin
                    if (w_issue) begin
                        r_shift    <= r_shift >> 8;
                        r_byte_cnt <= r_byte_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.tx_valid  = w_issue && !rst;
    assign bus.tx_data   = bus.tx_valid ? r_shift[7:0] : 8'h00;
    assign bus.eos_ready = bus.tx_valid && (r_state == S_MARK_SEND) && (r_byte_cnt == 4'd1);
endmodule

// File: tb/tb_rk4_tx_framer.sv
// Directed bench for rk4_tx_framer: byte order, latency, spacing, FIFO full/refusal, EOS marker, push+pop and mid-record reset.
module tb_rk4_tx_framer;
    localparam int         DEPTH   = 4;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
`ifdef RK4_FRAMER_CSUM_EN
    localparam int REC_BYTES = 9;
`else
    localparam int REC_BYTES = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] fifo_count;
    logic [2:0] dbg_state;
    rk4_tx_framer_if bus();

    rk4_tx_framer #(.FIFO_DEPTH(DEPTH), .MARKER(32'hDEADBEEF)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .fifo_count (fifo_count),
        .o_dbg_state(dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [7:0] exp_q[$];
    int         tx_cyc_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         eos_pulses = 0;
    int         tx_seen = 0;
    int         last_tx_cyc = -10;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte monitor: every strobe is matched against the expected queue and spacing is verified.
    always @(negedge clk) begin
        if (bus.eos_ready) eos_pulses++;
        if (bus.tx_valid) begin
            tx_seen++;
            tx_cyc_q.push_back(cyc);
            check("tx_spacing", 64'(cyc - last_tx_cyc >= 2), 64'd1);
            last_tx_cyc = cyc;
            check("tx_expected_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                check("tx_byte", 64'(bus.tx_data), 64'(exp_q.pop_front()));
            end
        end
    end

    // Driver tasks
    task automatic exp_rec(input logic [31:0] ti, input logic [31:0] yi);
        logic [63:0] w;
        logic [7:0]  cs;
        w  = {yi, ti};
        cs = 8'h00;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(w[8*i +: 8]);
            cs = cs ^ w[8*i +: 8];
        end
`ifdef RK4_FRAMER_CSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    task automatic push_raw(input logic [31:0] ti, input logic [31:0] yi, output int pcyc);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.rec_valid = 1'b1;
        bus.rec_ti    = ti;
        bus.rec_yi    = yi;
        while (!bus.rec_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        check("push_accepted", 64'(bus.rec_ready), 64'd1);
        pcyc = cyc;
        @(posedge clk);
        #1;
        bus.rec_valid = 1'b0;
    endtask

    task automatic push_rec(input logic [31:0] ti, input logic [31:0] yi);
        int pc;
        exp_rec(ti, yi);
        push_raw(ti, yi, pc);
    endtask

    task automatic wait_idle(input string tag);
        int  waited;
        logic done;
        waited = 0;
        done   = 1'b0;
        while (!done && waited < 3000) begin
            @(negedge clk);
            waited++;
            done = (exp_q.size() == 0) && (dbg_state == ST_IDLE) && (fifo_count == 3'd0);
        end
        check(tag, 64'(done), 64'd1);
    endtask

    // Stimulus
    initial begin : main
        int pc;
        int base;
        int waited;
        logic [31:0] t2_ti [5] = '{32'h0000_0001, 32'h1234_5678, 32'hFFFF_0000, 32'h00A5_5A00, 32'h8000_0001};
        logic [31:0] t2_yi [5] = '{32'h0001_0000, 32'h9ABC_DEF0, 32'h0000_FFFF, 32'h7FFF_FFFF, 32'hC3C3_3C3C};

        rst           = 1'b1;
        bus.rec_valid = 1'b0;
        bus.rec_ti    = 32'h0;
        bus.rec_yi    = 32'h0;
        bus.eos_valid = 1'b0;
        bus.tx_ready  = 1'b1;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_rec_ready", 64'(bus.rec_ready), 64'd0);
        check("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        check("rst_tx_data", 64'(bus.tx_data), 64'h00);
        check("rst_eos_ready", 64'(bus.eos_ready), 64'd0);
        check("rst_fifo_count", 64'(fifo_count), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rec_ready", 64'(bus.rec_ready), 64'd1);

        // Single record: byte order, latency and spacing
        base = tx_cyc_q.size();
        exp_q.push_back(8'h90); exp_q.push_back(8'h02); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'h80); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
`ifdef RK4_FRAMER_CSUM_EN
        exp_q.push_back(8'h13);
`endif
        push_raw(32'h0000_0290, 32'h0001_8000, pc);
        wait_idle("t1_drain");
        check("t1_byte_count", 64'(tx_cyc_q.size() - base), 64'(REC_BYTES));
        if (tx_cyc_q.size() - base == REC_BYTES) begin
            check("t1_latency", 64'(tx_cyc_q[base] - pc), 64'd3);
            for (int i = 1; i < REC_BYTES; i++) begin
                check("t1_strobe_gap", 64'(tx_cyc_q[base+i] - tx_cyc_q[base+i-1]), 64'd2);
            end
        end

        // FIFO fill with uart_tx stalled, then drain in order
        bus.tx_ready = 1'b0;
        base = tx_seen;
        for (int k = 0; k < 5; k++) push_rec(t2_ti[k], t2_yi[k]);
        @(negedge clk);
        check("t2_full_count", 64'(fifo_count), 64'd4);
        check("t2_full_ready", 64'(bus.rec_ready), 64'd0);
        bus.rec_valid = 1'b1;
        bus.rec_ti    = 32'hBAD0_BAD0;
        bus.rec_yi    = 32'hBAD1_BAD1;
        repeat (3) @(negedge clk);
        check("t2_refused_count", 64'(fifo_count), 64'd4);
        check("t2_no_tx_stalled", 64'(tx_seen - base), 64'd0);
        bus.rec_valid = 1'b0;
        bus.tx_ready  = 1'b1;
        wait_idle("t2_drain");
        check("t2_total_bytes", 64'(tx_seen - base), 64'(5 * REC_BYTES));

        // End-of-stream after two buffered records
        bus.tx_ready = 1'b0;
        base = eos_pulses;
        push_rec(32'h0000_1000, 32'hFFFE_8000);
        push_rec(32'h0000_2000, 32'h0003_4000);
        exp_q.push_back(8'hEF); exp_q.push_back(8'hBE); exp_q.push_back(8'hAD); exp_q.push_back(8'hDE);
        @(negedge clk);
        bus.eos_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("t3_eos_wait", 64'(bus.eos_ready), 64'd0);
        bus.tx_ready = 1'b1;
        waited = 0;
        while (!bus.eos_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("t3_eos_seen", 64'(bus.eos_ready), 64'd1);
        check("t3_eos_on_last_byte", 64'({bus.tx_valid, bus.tx_data}), 64'h1DE);
        bus.eos_valid = 1'b0;
        wait_idle("t3_drain");
        check("t3_eos_pulse_count", 64'(eos_pulses - base), 64'd1);

        // Push coinciding with pop at fifo_count=2
        bus.tx_ready = 1'b0;
        base = tx_seen;
        push_rec(32'h0000_00A1, 32'h0000_00B1);
        push_rec(32'h0000_00A2, 32'h0000_00B2);
        push_rec(32'h0000_00A3, 32'h0000_00B3);
        bus.tx_ready = 1'b1;
        waited = 0;
        @(negedge clk);
        while (dbg_state != ST_LOAD && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("t4_load_reached", 64'(dbg_state == ST_LOAD), 64'd1);
        check("t4_count_before", 64'(fifo_count), 64'd2);
        check("t4_ready_before", 64'(bus.rec_ready), 64'd1);
        exp_rec(32'h0000_00A4, 32'h0000_00B4);
        bus.rec_valid = 1'b1;
        bus.rec_ti    = 32'h0000_00A4;
        bus.rec_yi    = 32'h0000_00B4;
        @(posedge clk);
        #1;
        bus.rec_valid = 1'b0;
        @(negedge clk);
        check("t4_count_after", 64'(fifo_count), 64'd2);
        wait_idle("t4_drain");
        check("t4_total_bytes", 64'(tx_seen - base), 64'(4 * REC_BYTES));

        // Reset in the middle of a record
        base = tx_seen;
        push_rec(32'h1111_2222, 32'h3333_4444);
        push_raw(32'h5555_6666, 32'h7777_8888, pc);
        waited = 0;
        while (tx_seen - base < 3 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("t5_three_bytes", 64'(tx_seen - base), 64'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_count_flushed", 64'(fifo_count), 64'd0);
        repeat (30) @(negedge clk);
        check("t5_no_tx_after_rst", 64'(tx_seen - base), 64'd3);
        base = tx_seen;
        push_rec(32'hCAFE_0001, 32'h0BAD_F00D);
        wait_idle("t5_fresh_drain");
        check("t5_fresh_bytes", 64'(tx_seen - base), 64'(REC_BYTES));

`ifdef RK4_FRAMER_CSUM_EN
        // Checksum byte for a hand-computed record
        exp_q.push_back(8'h04); exp_q.push_back(8'h03); exp_q.push_back(8'h02); exp_q.push_back(8'h01);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h04);
        push_raw(32'h0102_0304, 32'h0000_0000, pc);
        wait_idle("t6_csum_drain");
`endif

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
